// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// The channel state machine enum and the default stability period live here.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    UP        = 2'd0,
    WAIT_DOWN = 2'd1,
    DOWN      = 2'd2,
    WAIT_UP   = 2'd3
  } key_state_e;

  // 10 ms at the 50 MHz board clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  // Counter width for a stability period; at least one bit for the smallest legal period.
  function automatic int debounce_cnt_w(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key bundle between the raw board pins and the design logic.
// The release strobe is called release_stb because release is a reserved word.
interface key_debounce_if #(
  parameter int NUM_KEYS = 2
);
  import key_debounce_pkg::*;

  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] release_stb;

  modport master (
    output key_n,
    input  key_level,
    input  press,
    input  release_stb
  );

  modport slave (
    input  key_n,
    output key_level,
    output press,
    output release_stb
  );

endinterface

// File: rtl/key_debounce_channel.sv
// One key: two-flop synchroniser, stability counter and four-state debounce FSM.
// Strobes are registered; key_level is decoded from the state register.
module key_debounce_channel
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic press,
  output logic release_stb
);

  localparam int CNT_W = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  key_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       press_q, press_d;
  logic       release_q, release_d;
  logic       s;

  // Synchronised key, 1 = pressed.
  assign s = ~sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= UP;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      UP: begin
        if (s) begin
          state_d = WAIT_DOWN;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_DOWN: begin
        if (!s) begin
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DOWN: begin
        if (!s) begin
          state_d = WAIT_UP;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_UP: begin
        if (s) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = UP;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = UP;
        cnt_d   = '0;
      end
    endcase
  end

  // The level stays high while a release is still being qualified.
  assign key_level   = (state_q == DOWN) || (state_q == WAIT_UP);
  assign press       = press_q;
  assign release_stb = release_q;

endmodule

// File: rtl/key_debounce.sv
// Debouncer for the lab board keys: one independent channel per key,
// outputs concatenated onto the key bundle.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic           clk,
  input  logic           reset,
  key_debounce_if.slave  bus
);

  logic [NUM_KEYS-1:0] level_w;
  logic [NUM_KEYS-1:0] press_w;
  logic [NUM_KEYS-1:0] release_w;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .key_n       (bus.key_n[i]),
      .key_level   (level_w[i]),
      .press       (press_w[i]),
      .release_stb (release_w[i])
    );
  end

  assign bus.key_level   = level_w;
  assign bus.press       = press_w;
  assign bus.release_stb = release_w;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: run-length reference model feeding a strobe scoreboard,
// directed scenarios with fixed latencies, randomized key traffic and a long-period instance.
module tb_key_debounce;

  localparam int NK      = 2;
  localparam int D       = 4;
  localparam int LARGE_D = 8192;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  key_debounce_if #(.NUM_KEYS(NK)) bus ();
  key_debounce_if #(.NUM_KEYS(1))  bus_l ();

  key_debounce #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  key_debounce #(.NUM_KEYS(1), .DEBOUNCE_CYCLES(LARGE_D)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
  );

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_cnt);
    end
  endtask

  // Reference model: a channel accepts a new level once D consecutive
  // synchronised samples (key_n delayed two edges) disagree with the current level.
  typedef struct {
    int            edge_n;
    logic [NK-1:0] prs;
    logic [NK-1:0] rel;
  } ev_t;

  ev_t           sb_q[$];
  logic [NK-1:0] m_level;
  logic [NK-1:0] m_d1, m_d2;
  int            m_run[NK];

  initial begin
    logic [NK-1:0] s, p, r;
    m_level = '0;
    m_d1    = '1;
    m_d2    = '1;
    for (int i = 0; i < NK; i++) m_run[i] = 0;
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (reset) begin
        m_d1    = '1;
        m_d2    = '1;
        m_level = '0;
        for (int i = 0; i < NK; i++) m_run[i] = 0;
      end else begin
        s = ~m_d2;
        p = '0;
        r = '0;
        for (int i = 0; i < NK; i++) begin
          if (s[i] != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == D) begin
              m_level[i] = s[i];
              m_run[i]   = 0;
              if (s[i]) p[i] = 1'b1;
              else      r[i] = 1'b1;
            end
          end else begin
            m_run[i] = 0;
          end
        end
        if ((p | r) != '0) sb_q.push_back('{edge_n: edge_cnt, prs: p, rel: r});
        m_d2 = m_d1;
        m_d1 = bus.key_n;
      end
    end
  end

  // Monitor: records DUT strobes and checks them against the scoreboard.
  int            press_cnt[NK];
  int            rel_cnt[NK];
  int            last_press_edge[NK];
  int            last_rel_edge[NK];
  logic [NK-1:0] last_press_vec;
  logic [NK-1:0] last_rel_vec;
  int            lp_cnt = 0;
  int            lr_cnt = 0;
  int            lp_edge = 0;

  initial begin
    ev_t ev;
    last_press_vec = '0;
    last_rel_vec   = '0;
    for (int i = 0; i < NK; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; last_press_edge[i] = 0; last_rel_edge[i] = 0;
    end
    forever begin
      @(negedge clk);
      chk("level", 32'(bus.key_level), 32'(m_level));
      if (sb_q.size() > 0 && sb_q[0].edge_n == edge_cnt) begin
        ev = sb_q.pop_front();
        chk("press", 32'(bus.press), 32'(ev.prs));
        chk("release", 32'(bus.release_stb), 32'(ev.rel));
      end else if ((bus.press | bus.release_stb) != '0) begin
        chk("unexpected_strobe", 32'({bus.press, bus.release_stb}), 32'd0);
      end
      for (int i = 0; i < NK; i++) begin
        if (bus.press[i] === 1'b1) begin press_cnt[i]++; last_press_edge[i] = edge_cnt; end
        if (bus.release_stb[i] === 1'b1) begin rel_cnt[i]++; last_rel_edge[i] = edge_cnt; end
      end
      if (bus.press != '0) last_press_vec = bus.press;
      if (bus.release_stb != '0) last_rel_vec = bus.release_stb;
      if (bus_l.press[0] === 1'b1) begin lp_cnt++; lp_edge = edge_cnt; end
      if (bus_l.release_stb[0] === 1'b1) lr_cnt++;
    end
  end

  task automatic hold(input logic [NK-1:0] v, input int n);
    bus.key_n = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int first, rfirst, pfirst, bp, br, bp1, n;
    logic [31:0] rv;
    bus.key_n   = '1;
    bus_l.key_n = '1;
    reset       = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_level", 32'(bus.key_level), 32'd0);
    chk("reset_press", 32'(bus.press), 32'd0);
    chk("reset_release", 32'(bus.release_stb), 32'd0);
    chk("reset_large_level", 32'(bus_l.key_level), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Clean press on key 0, key 1 idle.
    first = edge_cnt + 1;
    bp = press_cnt[0];
    hold(2'b10, D + 4);
    chk("clean_press_edge", 32'(last_press_edge[0] - first + 1), 32'(D + 2));
    chk("clean_press_count", 32'(press_cnt[0] - bp), 32'd1);
    chk("clean_level", 32'(bus.key_level), 32'b01);
    chk("clean_ch1_quiet", 32'(press_cnt[1] + rel_cnt[1]), 32'd0);
    hold(2'b11, D + 6);

    // Bounce rejection.
    bp = press_cnt[0];
    br = rel_cnt[0];
    hold(2'b10, 2); hold(2'b11, 1); hold(2'b10, 2); hold(2'b11, D + 6);
    chk("bounce_press", 32'(press_cnt[0] - bp), 32'd0);
    chk("bounce_release", 32'(rel_cnt[0] - br), 32'd0);
    chk("bounce_level", 32'(bus.key_level), 32'd0);

    // Press, hold 20 cycles, release.
    bp = press_cnt[0];
    br = rel_cnt[0];
    first = edge_cnt + 1;
    hold(2'b10, 20);
    chk("held_level", 32'(bus.key_level), 32'b01);
    rfirst = edge_cnt + 1;
    hold(2'b11, D + 6);
    chk("pr_press_edge", 32'(last_press_edge[0] - first + 1), 32'(D + 2));
    chk("pr_release_edge", 32'(last_rel_edge[0] - rfirst + 1), 32'(D + 2));
    chk("pr_counts", 32'({16'(press_cnt[0] - bp), 16'(rel_cnt[0] - br)}), 32'h0001_0001);
    chk("pr_level_after", 32'(bus.key_level), 32'd0);

    // Reset on the fourth edge of a debounce, key kept low.
    bp = press_cnt[0];
    bus.key_n = 2'b10;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_no_press", 32'(press_cnt[0] - bp), 32'd0);
    pfirst = edge_cnt + 1;
    hold(2'b10, D + 6);
    chk("rst_mid_press_edge", 32'(last_press_edge[0] - pfirst + 1), 32'(D + 2));
    chk("rst_mid_press_count", 32'(press_cnt[0] - bp), 32'd1);
    hold(2'b11, D + 6);

    // Both keys together, then release key 1 only.
    first = edge_cnt + 1;
    hold(2'b00, D + 6);
    chk("sim_press_vec", 32'(last_press_vec), 32'b11);
    chk("sim_press_edge0", 32'(last_press_edge[0] - first + 1), 32'(D + 2));
    chk("sim_press_edge1", 32'(last_press_edge[1] - first + 1), 32'(D + 2));
    rfirst = edge_cnt + 1;
    br = rel_cnt[0];
    hold(2'b10, D + 6);
    chk("sim_release_vec", 32'(last_rel_vec), 32'b10);
    chk("sim_release_edge", 32'(last_rel_edge[1] - rfirst + 1), 32'(D + 2));
    chk("sim_release_ch0_quiet", 32'(rel_cnt[0] - br), 32'd0);
    chk("sim_level", 32'(bus.key_level), 32'b01);
    hold(2'b11, D + 6);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 300; k++) begin
      rv = $urandom;
      n  = $urandom_range(1, 2 * D);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        hold(rv[NK-1:0], 1);
        reset = 1'b0;
      end
      hold(rv[NK-1:0], n);
    end
    hold(2'b11, D + 8);
    chk("random_idle_level", 32'(bus.key_level), 32'd0);

    // Long stability period.
    bp1 = lp_cnt;
    first = edge_cnt + 1;
    bus_l.key_n = 1'b0;
    for (int c = 0; c < LARGE_D + 20 && lp_cnt == bp1; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("large_press_edge", 32'(lp_edge - first + 1), 32'(LARGE_D + 2));
    chk("large_press_count", 32'(lp_cnt - bp1), 32'd1);
    chk("large_level", 32'(bus_l.key_level), 32'd1);
    chk("large_no_release", 32'(lr_cnt), 32'd0);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
